// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: pipelined requests to instruction memory with a
// DEPTH-entry PC-tagged queue toward decode; redirect flushes and drops in-flight replies.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    input  logic        id_ready,
    output logic        resp_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
    } entry_t;

    entry_t      ring_q [DEPTH];
    entry_t      ring_d [DEPTH];
    logic [31:0] fetch_pc_q, fetch_pc_d;
    ptr_t        alloc_q, alloc_d;
    ptr_t        fill_q, fill_d;
    ptr_t        read_q, read_d;
    cnt_t        used_q, used_d;
    cnt_t        pend_q, pend_d;
    cnt_t        drop_q, drop_d;
    logic        resp_err_q, resp_err_d;

    logic [CW:0] occupancy;
    logic        grant;
    logic        deq;
    logic        resp_expected;
    logic        fill_en;
    logic        unused_pc_lsbs;

    // Requests count against both live entries and replies still owed to a flushed stream.
    assign occupancy      = {1'b0, used_q} + {1'b0, drop_q};
    assign imem_req       = reset && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr      = fetch_pc_q;
    assign id_valid       = !redirect_valid && (used_q != '0) && ring_q[read_q].filled;
    assign id_pc          = ring_q[read_q].pc;
    assign id_instr       = ring_q[read_q].instr;
    assign resp_err       = resp_err_q;
    assign grant          = imem_req && imem_gnt;
    assign deq            = id_valid && id_ready;
    assign resp_expected  = (drop_q != '0) || (pend_q != '0);
    assign fill_en        = imem_rvalid && !redirect_valid && (drop_q == '0) && (pend_q != '0);
    assign unused_pc_lsbs = ^redirect_pc[1:0];

    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        ring_d     = ring_q;
        fetch_pc_d = fetch_pc_q;
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        read_d     = read_q;
        used_d     = used_q;
        pend_d     = pend_q;
        drop_d     = drop_q;
        resp_err_d = resp_err_q || (imem_rvalid && !resp_expected);

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            alloc_d    = '0;
            fill_d     = '0;
            read_d     = '0;
            used_d     = '0;
            pend_d     = '0;
            // Replies owed to the flushed entries become drops; one arriving now is consumed here.
            drop_d     = drop_q + pend_q - cnt_t'(imem_rvalid && resp_expected);
            for (int i = 0; i < DEPTH; i++) ring_d[i].filled = 1'b0;
        end else begin
            if (grant) begin
                ring_d[alloc_q].pc     = fetch_pc_q;
                ring_d[alloc_q].filled = 1'b0;
                alloc_d                = alloc_q + ptr_t'(1);
                fetch_pc_d             = fetch_pc_q + 32'd4;
            end
            if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - cnt_t'(1);
            if (fill_en) begin
                ring_d[fill_q].instr  = imem_rdata;
                ring_d[fill_q].filled = 1'b1;
                fill_d                = fill_q + ptr_t'(1);
            end
            if (deq) begin
                ring_d[read_q].filled = 1'b0;
                read_d                = read_q + ptr_t'(1);
            end
            used_d = used_q + cnt_t'(grant) - cnt_t'(deq);
            pend_d = pend_q + cnt_t'(grant) - cnt_t'(fill_en);
        end
    end

    // NOTE: state updates use non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the ring is reset (not left as plain RAM) because id_pc/id_instr must read zero under reset.
            for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
            fetch_pc_q <= RESET_PC;
            alloc_q    <= '0;
            fill_q     <= '0;
            read_q     <= '0;
            used_q     <= '0;
            pend_q     <= '0;
            drop_q     <= '0;
            resp_err_q <= 1'b0;
        end else begin
            ring_q     <= ring_d;
            fetch_pc_q <= fetch_pc_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            read_q     <= read_d;
            used_q     <= used_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            resp_err_q <= resp_err_d;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: in-order memory model with configurable latency
// and grant stalls, plus a second instance (RESET_PC=0x8000_0000) driven by hand.
module tb_if_fetch_queue;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, redirect_valid, id_ready;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_gnt, imem_rvalid, id_valid, resp_err;
    logic [31:0] imem_addr, imem_rdata, id_pc, id_instr;

    logic        u_gnt, u_rvalid, u_ready;
    logic [31:0] u_rdata;
    logic        u_req, u_idv, u_err;
    logic [31:0] u_addr, u_pc, u_instr;

    if_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready),
        .resp_err(resp_err)
    );

    if_fetch_queue #(.RESET_PC(32'h8000_0000), .DEPTH(4)) dut2 (
        .clk(clk), .reset(reset), .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
        .imem_req(u_req), .imem_addr(u_addr), .imem_gnt(u_gnt),
        .imem_rvalid(u_rvalid), .imem_rdata(u_rdata),
        .id_valid(u_idv), .id_pc(u_pc), .id_instr(u_instr), .id_ready(u_ready),
        .resp_err(u_err)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t mq[$];
    int    cyc, lat_min, lat_max, gnt_pct;
    int    errors = 0;
    int    checks = 0;

    logic        s_req, s_gnt, s_rvalid, s_idv, s_hs, s_err;
    logic [31:0] s_addr, s_pc, s_instr;
    logic        su_req, su_idv, su_err;
    logic [31:0] su_addr, su_pc, su_instr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0003;
    endfunction

    // One clock: drive memory side, sample just after, then advance to the next falling edge.
    task automatic cycle();
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        imem_gnt = ($urandom_range(99) < gnt_pct);
        #1;
        s_req = imem_req; s_addr = imem_addr; s_gnt = imem_gnt; s_rvalid = imem_rvalid;
        s_idv = id_valid; s_pc = id_pc; s_instr = id_instr; s_err = resp_err;
        s_hs  = id_valid && id_ready;
        su_req = u_req; su_addr = u_addr; su_idv = u_idv; su_pc = u_pc;
        su_instr = u_instr; su_err = u_err;
        if (!reset) mq.delete();
        else if (imem_req && imem_gnt)
            mq.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0;
        u_gnt = 1'b0; u_rvalid = 1'b0; u_ready = 1'b0;
        mq.delete();
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        gnt_pct = 100;
        cycle();
        cycle();
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", s_req); end
        checks++; if (s_idv !== 1'b0) begin errors++; $display("FAIL reset_idv: got %b want 0", s_idv); end
        checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", s_addr); end
        checks++; if (s_pc !== 32'h0 || s_instr !== 32'h0) begin errors++; $display("FAIL reset_id: got pc=%h instr=%h want 0/0", s_pc, s_instr); end
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", s_err); end
        checks++; if (su_addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_addr2: got %h want 80000000", su_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] epc;
        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1; id_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            checks++; if (s_req !== 1'b1 || s_addr !== 32'(4*(k-1))) begin errors++; $display("FAIL stream_req k=%0d: got req=%b addr=%h want 1/%h", k, s_req, s_addr, 32'(4*(k-1))); end
            if (k < 3) begin
                checks++; if (s_idv !== 1'b0) begin errors++; $display("FAIL stream_early k=%0d: got idv=%b want 0", k, s_idv); end
            end else begin
                epc = 32'(4*(k-3));
                checks++; if (s_idv !== 1'b1 || s_pc !== epc || s_instr !== instr_of(epc)) begin errors++; $display("FAIL stream_id k=%0d: got v=%b pc=%h instr=%h want 1/%h/%h", k, s_idv, s_pc, s_instr, epc, instr_of(epc)); end
            end
        end
    endtask

    task automatic test_full();
        int  grants;
        logic found;
        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1; id_ready = 1'b0;
        grants = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (s_req && s_gnt) grants++;
        end
        checks++; if (grants !== 4) begin errors++; $display("FAIL full_grants: got %0d want 4", grants); end
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL full_req: got %b want 0", s_req); end
        checks++; if (s_idv !== 1'b1 || s_pc !== 32'h0) begin errors++; $display("FAIL full_head: got v=%b pc=%h want 1/0", s_idv, s_pc); end
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++; if (s_idv !== 1'b1 || s_pc !== 32'(4*i) || s_instr !== instr_of(32'(4*i))) begin errors++; $display("FAIL full_drain i=%0d: got v=%b pc=%h want 1/%h", i, s_idv, s_pc, 32'(4*i)); end
            if (i == 0) begin
                checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL full_drain_req: got %b want 0", s_req); end
            end
            if (i == 1) begin
                checks++; if (s_req !== 1'b1 || s_addr !== 32'h10) begin errors++; $display("FAIL full_resume: got req=%b addr=%h want 1/10", s_req, s_addr); end
            end
        end
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            cycle();
            if (s_hs) begin
                found = 1'b1;
                checks++; if (s_pc !== 32'h10) begin errors++; $display("FAIL full_next: got pc=%h want 10", s_pc); end
            end
        end
        if (!found) begin checks++; errors++; $display("FAIL full_next: got no handshake want pc=10"); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, prev_addr;
        logic        prev_stall;
        int          hs;
        do_reset();
        gnt_pct = 60; lat_min = 1; lat_max = 5;
        exp_pc = 32'h0; prev_stall = 1'b0; prev_addr = 32'h0; hs = 0;
        for (int n = 0; n < 400; n++) begin
            id_ready = ($urandom_range(3) != 0);
            cycle();
            if (prev_stall) begin
                checks++; if (s_req !== 1'b1 || s_addr !== prev_addr) begin errors++; $display("FAIL rand_stable n=%0d: got req=%b addr=%h want 1/%h", n, s_req, s_addr, prev_addr); end
            end
            prev_stall = s_req && !s_gnt;
            prev_addr  = s_addr;
            if (s_hs) begin
                checks++; if (s_pc !== exp_pc || s_instr !== instr_of(exp_pc)) begin errors++; $display("FAIL rand_order n=%0d: got pc=%h instr=%h want %h/%h", n, s_pc, s_instr, exp_pc, instr_of(exp_pc)); end
                exp_pc += 32'd4;
                hs++;
            end
        end
        checks++; if (hs < 50) begin errors++; $display("FAIL rand_rate: got %0d handshakes want >=50", hs); end
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL rand_err: got %b want 0", s_err); end
    endtask

    task automatic test_redirect();
        logic found;
        do_reset();
        gnt_pct = 100; lat_min = 5; lat_max = 5; id_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        cycle();
        checks++; if (s_req !== 1'b0 || s_idv !== 1'b0) begin errors++; $display("FAIL redir_mask: got req=%b idv=%b want 0/0", s_req, s_idv); end
        redirect_valid = 1'b0;
        cycle();
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin errors++; $display("FAIL redir_addr: got req=%b addr=%h want 1/100", s_req, s_addr); end
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            cycle();
            if (s_hs) begin
                found = 1'b1;
                checks++; if (s_pc !== 32'h100 || s_instr !== instr_of(32'h100)) begin errors++; $display("FAIL redir_first: got pc=%h instr=%h want 100/%h", s_pc, s_instr, instr_of(32'h100)); end
            end
        end
        if (!found) begin checks++; errors++; $display("FAIL redir_first: got no handshake want pc=100"); end
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL redir_err: got %b want 0", s_err); end
    endtask

    task automatic test_redirect_rvalid();
        logic found;
        do_reset();
        gnt_pct = 100; lat_min = 2; lat_max = 2; id_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        cycle();
        checks++; if (s_rvalid !== 1'b1 || s_idv !== 1'b0 || s_req !== 1'b0) begin errors++; $display("FAIL rr_cycle: got rvalid=%b idv=%b req=%b want 1/0/0", s_rvalid, s_idv, s_req); end
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (s_hs) begin
                found = 1'b1;
                checks++; if (s_pc !== 32'h40 || s_instr !== instr_of(32'h40)) begin errors++; $display("FAIL rr_first: got pc=%h instr=%h want 40/%h", s_pc, s_instr, instr_of(32'h40)); end
            end
        end
        if (!found) begin checks++; errors++; $display("FAIL rr_first: got no handshake want pc=40"); end
        cycle();
        checks++; if (s_hs !== 1'b1 || s_pc !== 32'h44) begin errors++; $display("FAIL rr_second: got hs=%b pc=%h want 1/44", s_hs, s_pc); end
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL rr_err: got %b want 0", s_err); end
    endtask

    task automatic test_unsolicited();
        do_reset();
        u_gnt = 1'b0; u_rvalid = 1'b1; u_rdata = 32'hFFFF_FFFF;
        cycle();
        checks++; if (su_req !== 1'b1 || su_addr !== 32'h8000_0000 || su_err !== 1'b0) begin errors++; $display("FAIL uns_pre: got req=%b addr=%h err=%b want 1/80000000/0", su_req, su_addr, su_err); end
        u_rvalid = 1'b0;
        cycle();
        checks++; if (su_err !== 1'b1) begin errors++; $display("FAIL uns_err: got %b want 1", su_err); end
        checks++; if (su_idv !== 1'b0 || su_req !== 1'b1 || su_addr !== 32'h8000_0000) begin errors++; $display("FAIL uns_queue: got idv=%b req=%b addr=%h want 0/1/80000000", su_idv, su_req, su_addr); end
        u_gnt = 1'b1;
        cycle();
        u_gnt = 1'b0; u_rvalid = 1'b1; u_rdata = 32'h1234_5678;
        cycle();
        checks++; if (su_idv !== 1'b0) begin errors++; $display("FAIL uns_fill_lat: got idv=%b want 0", su_idv); end
        u_rvalid = 1'b0; u_ready = 1'b1;
        cycle();
        checks++; if (su_idv !== 1'b1 || su_pc !== 32'h8000_0000 || su_instr !== 32'h1234_5678) begin errors++; $display("FAIL uns_id: got v=%b pc=%h instr=%h want 1/80000000/12345678", su_idv, su_pc, su_instr); end
        checks++; if (su_addr !== 32'h8000_0004 || su_err !== 1'b1) begin errors++; $display("FAIL uns_next: got addr=%h err=%b want 80000004/1", su_addr, su_err); end
        u_ready = 1'b0;
        cycle();
        checks++; if (su_idv !== 1'b0 || su_err !== 1'b1) begin errors++; $display("FAIL uns_after: got idv=%b err=%b want 0/1", su_idv, su_err); end
    endtask

    initial begin
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        u_gnt = 1'b0; u_rvalid = 1'b0; u_rdata = 32'h0; u_ready = 1'b0;
        cyc = 0; gnt_pct = 100; lat_min = 1; lat_max = 1;
        @(negedge clk);
        test_reset();
        test_stream();
        test_full();
        test_random();
        test_redirect();
        test_redirect_rvalid();
        test_unsolicited();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
